// File: rtl/alu_wb_stage.sv
// alu_wb_stage: result/writeback stage downstream of the ALU.
// Captures ALU low/high results and NZCV flags, then sequences one register-file
// write (normal op) or two writes, RdLo then RdHi (64-bit long multiply).
// Optional feature macro: ALU_WB_PERF_EN adds a saturating long_wb_count output.
module alu_wb_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] alu_result_hi,
    input  logic [3:0]        alu_flags,
    input  logic [1:0]        flag_write,
    input  logic              reg_write,
    input  logic              is_long,
    input  logic [ADDR_W-1:0] rd_lo,
    input  logic [ADDR_W-1:0] rd_hi,
    output logic              wb_en,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] alu_out,
    output logic [3:0]        flags,
    output logic              done
`ifdef ALU_WB_PERF_EN
    ,
    output logic [31:0]       long_wb_count
`endif
);

    typedef enum logic [1:0] {StIdle, StWbLo, StWbHi} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] alu_out_q, alu_out_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [3:0]        flags_q, flags_d;
    logic [ADDR_W-1:0] rd_lo_q, rd_lo_d;
    logic [ADDR_W-1:0] rd_hi_q, rd_hi_d;
    logic              reg_write_q, reg_write_d;
    logic              is_long_q, is_long_d;
    logic              accept;

    assign accept = alu_valid && (state_q == StIdle);

    // Next-state: capture on accept, otherwise walk IDLE -> WB_LO -> (WB_HI) -> IDLE.
    always_comb begin
        state_d     = state_q;
        alu_out_d   = alu_out_q;
        hi_d        = hi_q;
        flags_d     = flags_q;
        rd_lo_d     = rd_lo_q;
        rd_hi_d     = rd_hi_q;
        reg_write_d = reg_write_q;
        is_long_d   = is_long_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    alu_out_d   = alu_result;
                    hi_d        = alu_result_hi;
                    rd_lo_d     = rd_lo;
                    rd_hi_d     = rd_hi;
                    reg_write_d = reg_write;
                    is_long_d   = is_long;
                    // flag_write[1] covers N,Z; flag_write[0] covers C,V
                    if (flag_write[1]) flags_d[3:2] = alu_flags[3:2];
                    if (flag_write[0]) flags_d[1:0] = alu_flags[1:0];
                    state_d = StWbLo;
                end
            end
            StWbLo: state_d = (reg_write_q && is_long_q) ? StWbHi : StIdle;
            StWbHi: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State and holding registers; reset drops any pending write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            alu_out_q   <= '0;
            hi_q        <= '0;
            flags_q     <= '0;
            rd_lo_q     <= '0;
            rd_hi_q     <= '0;
            reg_write_q <= 1'b0;
            is_long_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            alu_out_q   <= alu_out_d;
            hi_q        <= hi_d;
            flags_q     <= flags_d;
            rd_lo_q     <= rd_lo_d;
            rd_hi_q     <= rd_hi_d;
            reg_write_q <= reg_write_d;
            is_long_q   <= is_long_d;
        end
    end

    // Outputs decode state and captured registers only; no input-to-output path.
    always_comb begin
        wb_en   = 1'b0;
        wb_addr = '0;
        wb_data = '0;
        done    = 1'b0;
        unique case (state_q)
            StWbLo: begin
                wb_en   = reg_write_q;
                wb_addr = rd_lo_q;
                wb_data = alu_out_q;
                done    = !(reg_write_q && is_long_q);
            end
            StWbHi: begin
                wb_en   = 1'b1;
                wb_addr = rd_hi_q;
                wb_data = hi_q;
                done    = 1'b1;
            end
            default: ;
        endcase
    end

    assign alu_ready = (state_q == StIdle);
    assign alu_out   = alu_out_q;
    assign flags     = flags_q;

`ifdef ALU_WB_PERF_EN
    logic [31:0] cnt_q, cnt_d;

    // Count high-word writebacks, saturating at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == StWbHi && cnt_q != 32'hFFFF_FFFF) cnt_d = cnt_q + 32'd1;
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign long_wb_count = cnt_q;
`endif

endmodule

// File: tb/tb_alu_wb_stage.sv
// Directed self-checking bench for alu_wb_stage.
module tb_alu_wb_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        alu_valid = 1'b0;
    logic        alu_ready;
    logic [31:0] alu_result = '0;
    logic [31:0] alu_result_hi = '0;
    logic [3:0]  alu_flags = '0;
    logic [1:0]  flag_write = '0;
    logic        reg_write = 1'b0;
    logic        is_long = 1'b0;
    logic [3:0]  rd_lo = '0;
    logic [3:0]  rd_hi = '0;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] alu_out;
    logic [3:0]  flags;
    logic        done;
`ifdef ALU_WB_PERF_EN
    logic [31:0] long_wb_count;
`endif

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_wb_stage #(.DATA_W(32), .ADDR_W(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .alu_valid     (alu_valid),
        .alu_ready     (alu_ready),
        .alu_result    (alu_result),
        .alu_result_hi (alu_result_hi),
        .alu_flags     (alu_flags),
        .flag_write    (flag_write),
        .reg_write     (reg_write),
        .is_long       (is_long),
        .rd_lo         (rd_lo),
        .rd_hi         (rd_hi),
        .wb_en         (wb_en),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .alu_out       (alu_out),
        .flags         (flags),
        .done          (done)
`ifdef ALU_WB_PERF_EN
        ,
        .long_wb_count (long_wb_count)
`endif
    );

    // Present one op on a negedge, leave 1ns after the accepting posedge (now in WB_LO).
    task automatic do_accept(input logic [31:0] res, input logic [31:0] hi,
                             input logic [3:0] fl, input logic [1:0] fw,
                             input logic rw, input logic lng,
                             input logic [3:0] lo_a, input logic [3:0] hi_a);
        @(negedge clk);
        alu_result = res; alu_result_hi = hi; alu_flags = fl; flag_write = fw;
        reg_write = rw; is_long = lng; rd_lo = lo_a; rd_hi = hi_a; alu_valid = 1'b1;
        @(posedge clk); #1;
        alu_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #12;
        n_checks++; if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b exp 1", alu_ready); end
        n_checks++; if (wb_en !== 1'b0) begin n_fail++; $display("FAIL rst_wb_en got %b exp 0", wb_en); end
        n_checks++; if (flags !== 4'h0) begin n_fail++; $display("FAIL rst_flags got %h exp 0", flags); end
        n_checks++; if (alu_out !== 32'h0) begin n_fail++; $display("FAIL rst_alu_out got %h exp 0", alu_out); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done got %b exp 0", done); end
        n_checks++; if (wb_data !== 32'h0 || wb_addr !== 4'h0) begin n_fail++; $display("FAIL rst_wb got %h/%h exp 0/0", wb_addr, wb_data); end
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_add();
        do_accept(32'h5, 32'h0, 4'b0000, 2'b11, 1'b1, 1'b0, 4'd3, 4'd0);
        n_checks++; if (wb_en !== 1'b1) begin n_fail++; $display("FAIL add_wb_en got %b exp 1", wb_en); end
        n_checks++; if (wb_addr !== 4'd3) begin n_fail++; $display("FAIL add_addr got %h exp 3", wb_addr); end
        n_checks++; if (wb_data !== 32'h5) begin n_fail++; $display("FAIL add_data got %h exp 5", wb_data); end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL add_done got %b exp 1", done); end
        n_checks++; if (alu_ready !== 1'b0) begin n_fail++; $display("FAIL add_busy got %b exp 0", alu_ready); end
        n_checks++; if (alu_out !== 32'h5) begin n_fail++; $display("FAIL add_alu_out got %h exp 5", alu_out); end
        step();
        n_checks++; if (alu_ready !== 1'b1 || done !== 1'b0 || wb_en !== 1'b0) begin n_fail++; $display("FAIL add_idle got ready=%b done=%b en=%b exp 1/0/0", alu_ready, done, wb_en); end
    endtask

    task automatic test_smul();
        do_accept(32'hFFFF_FFFA, 32'hFFFF_FFFF, 4'b0000, 2'b00, 1'b1, 1'b1, 4'd4, 4'd5);
        n_checks++; if (wb_en !== 1'b1 || wb_addr !== 4'd4 || wb_data !== 32'hFFFF_FFFA) begin n_fail++; $display("FAIL smul_lo got en=%b a=%h d=%h exp 1/4/fffffffa", wb_en, wb_addr, wb_data); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL smul_lo_done got %b exp 0", done); end
        step();
        n_checks++; if (wb_en !== 1'b1 || wb_addr !== 4'd5 || wb_data !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL smul_hi got en=%b a=%h d=%h exp 1/5/ffffffff", wb_en, wb_addr, wb_data); end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL smul_hi_done got %b exp 1", done); end
        step();
`ifdef ALU_WB_PERF_EN
        n_checks++; if (long_wb_count !== 32'd1) begin n_fail++; $display("FAIL smul_count got %0d exp 1", long_wb_count); end
`endif
        n_checks++; if (alu_ready !== 1'b1 || wb_en !== 1'b0) begin n_fail++; $display("FAIL smul_idle got ready=%b en=%b exp 1/0", alu_ready, wb_en); end
    endtask

    task automatic test_partial_flags();
        do_accept(32'h0, 32'h0, 4'b1111, 2'b11, 1'b0, 1'b0, 4'd0, 4'd0);
        step();
        n_checks++; if (flags !== 4'b1111) begin n_fail++; $display("FAIL pf_preload got %b exp 1111", flags); end
        do_accept(32'h0, 32'h0, 4'b0100, 2'b10, 1'b0, 1'b0, 4'd0, 4'd0);
        n_checks++; if (flags !== 4'b0111) begin n_fail++; $display("FAIL pf_nz got %b exp 0111", flags); end
        step();
    endtask

    task automatic test_busy_ignore();
        do_accept(32'h1234, 32'h0, 4'b0001, 2'b01, 1'b1, 1'b0, 4'd2, 4'd0);
        @(negedge clk);
        alu_result = 32'hDEAD_BEEF; alu_flags = 4'b1010; flag_write = 2'b11; rd_lo = 4'd9;
        alu_valid = 1'b1;
        n_checks++; if (wb_addr !== 4'd2 || wb_data !== 32'h1234) begin n_fail++; $display("FAIL busy_wb got a=%h d=%h exp 2/1234", wb_addr, wb_data); end
        @(posedge clk); #1;
        alu_valid = 1'b0;
        n_checks++; if (alu_out !== 32'h1234) begin n_fail++; $display("FAIL busy_alu_out got %h exp 1234", alu_out); end
        n_checks++; if (flags !== 4'b0101) begin n_fail++; $display("FAIL busy_flags got %b exp 0101", flags); end
        n_checks++; if (done !== 1'b0 || wb_en !== 1'b0 || alu_ready !== 1'b1) begin n_fail++; $display("FAIL busy_idle got done=%b en=%b ready=%b exp 0/0/1", done, wb_en, alu_ready); end
        step();
        n_checks++; if (done !== 1'b0 || wb_en !== 1'b0) begin n_fail++; $display("FAIL busy_extra got done=%b en=%b exp 0/0", done, wb_en); end
    endtask

    task automatic test_reset_mid();
        do_accept(32'hAAAA_0001, 32'hBBBB_0002, 4'b1001, 2'b11, 1'b1, 1'b1, 4'd1, 4'd2);
        n_checks++; if (wb_en !== 1'b1) begin n_fail++; $display("FAIL rm_pre got %b exp 1", wb_en); end
        #2; reset = 1'b1; #1;
        n_checks++; if (wb_en !== 1'b0) begin n_fail++; $display("FAIL rm_async_en got %b exp 0", wb_en); end
        n_checks++; if (flags !== 4'h0 || alu_ready !== 1'b1) begin n_fail++; $display("FAIL rm_async got flags=%b ready=%b exp 0000/1", flags, alu_ready); end
        @(negedge clk); reset = 1'b0;
        step();
        n_checks++; if (wb_en !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rm_no_hi got en=%b done=%b exp 0/0", wb_en, done); end
`ifdef ALU_WB_PERF_EN
        n_checks++; if (long_wb_count !== 32'd0) begin n_fail++; $display("FAIL rm_count got %0d exp 0", long_wb_count); end
`endif
    endtask

    task automatic test_alias();
        do_accept(32'h1111_1111, 32'h2222_2222, 4'b0000, 2'b00, 1'b1, 1'b1, 4'd7, 4'd7);
        n_checks++; if (wb_en !== 1'b1 || wb_addr !== 4'd7 || wb_data !== 32'h1111_1111) begin n_fail++; $display("FAIL alias_lo got en=%b a=%h d=%h exp 1/7/11111111", wb_en, wb_addr, wb_data); end
        step();
        n_checks++; if (wb_en !== 1'b1 || wb_addr !== 4'd7 || wb_data !== 32'h2222_2222 || done !== 1'b1) begin n_fail++; $display("FAIL alias_hi got en=%b a=%h d=%h done=%b exp 1/7/22222222/1", wb_en, wb_addr, wb_data, done); end
        step();
`ifdef ALU_WB_PERF_EN
        n_checks++; if (long_wb_count !== 32'd1) begin n_fail++; $display("FAIL alias_count got %0d exp 1", long_wb_count); end
`endif
    endtask

    task automatic test_long_nowrite();
        do_accept(32'h3, 32'h4, 4'b0000, 2'b00, 1'b0, 1'b1, 4'd8, 4'd9);
        n_checks++; if (wb_en !== 1'b0 || done !== 1'b1) begin n_fail++; $display("FAIL lnw_lo got en=%b done=%b exp 0/1", wb_en, done); end
        step();
        n_checks++; if (wb_en !== 1'b0 || done !== 1'b0 || alu_ready !== 1'b1) begin n_fail++; $display("FAIL lnw_after got en=%b done=%b ready=%b exp 0/0/1", wb_en, done, alu_ready); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_smul();
        test_partial_flags();
        test_busy_ignore();
        test_reset_mid();
        test_alias();
        test_long_nowrite();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_wb_stage.md
Name: alu_wb_stage

Overview:
- Result/writeback stage directly downstream of the ALU in the multi-cycle core.
- Captures the ALU low result, high result and NZCV flags into architectural holding registers.
- Sequences register-file writes through the single write port: one write for normal ops; two consecutive writes (RdLo, then RdHi) for 64-bit long multiplies (SMUL/UMUL).
- Hands a done pulse back to the main controller FSM.

Parameters:
- DATA_W, 32, width of the ALU result, the high result and the write data.
- ADDR_W, 4, register-file address width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- alu_valid  input  1  controller strobe; ALU outputs and controls are valid this cycle.
- alu_ready  output  1  stage can accept alu_valid; high only in IDLE.
- alu_result  input  DATA_W  ALU Result (low word).
- alu_result_hi  input  DATA_W  ALU ResultHi (high word, long multiply).
- alu_flags  input  4  ALU flags {N,Z,C,V}.
- flag_write  input  2  [1] updates N,Z; [0] updates C,V.
- reg_write  input  1  operation writes the register file.
- is_long  input  1  64-bit result; write both words.
- rd_lo  input  ADDR_W  destination for the low word.
- rd_hi  input  ADDR_W  destination for the high word.
- wb_en  output  1  register-file write enable.
- wb_addr  output  ADDR_W  register-file write address.
- wb_data  output  DATA_W  register-file write data.
- alu_out  output  DATA_W  registered low result (ALUOut) for address and branch use.
- flags  output  4  architectural NZCV register.
- done  output  1  one-cycle pulse in the final cycle of the operation.

Behaviour:
- Reset values: state=IDLE; alu_out=0; flags=0; captured hi/addrs/ctrls=0; wb_en=0; wb_addr=0; wb_data=0; done=0; alu_ready=1.
  - Reset is asynchronous and may hit any state; the next state is IDLE and any pending write is dropped.
- FSM states: IDLE, WB_LO, WB_HI.
- Acceptance: alu_valid sampled high at edge N while in IDLE captures:
  - alu_result → alu_out; alu_result_hi → hi_q.
  - rd_lo, rd_hi, reg_write, is_long.
  - flags bits per flag_write, at edge N; the other bits hold.
  - Then IDLE → WB_LO.
- alu_valid while not IDLE is ignored: no capture, no flag change. This is a controller protocol error, so no assertion is required.
- WB_LO (cycle N+1): wb_en=reg_write; wb_addr=rd_lo_q; wb_data=alu_out.
  - If reg_write_q & is_long_q → WB_HI, done=0.
  - Else → IDLE, done=1.
- WB_HI (cycle N+2): wb_en=1; wb_addr=rd_hi_q; wb_data=hi_q; done=1; → IDLE.
- is_long with reg_write=0: no writes, no WB_HI, done in WB_LO.
- rd_lo==rd_hi on a long op: both writes are issued in order, so the register ends holding the high word.
- Latency from accept to done: 1 cycle for a normal op, 2 cycles for a long op.
  - Back-to-back throughput: one op every 2 cycles (normal) or every 3 cycles (long), since IDLE is always revisited.
- wb_* and done are combinational decodes of state and captured registers only; there is no input-to-output combinational path.
- alu_out and flags hold their values until the next accepted op.

Optional Feature:
- Macro: ALU_WB_PERF_EN.
- Defined: adds output port long_wb_count (32 bits), reset 0.
  - Increments by 1 on each WB_HI cycle.
  - Saturates at 32'hFFFF_FFFF; no wrap.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- ADD accept: alu_result=32'h0000_0005, reg_write=1, rd_lo=3, flag_write=2'b11, alu_flags=4'b0000.
  - Next cycle: wb_en=1, wb_addr=3, wb_data=5, done=1; flags=0; then alu_ready=1.
- SMUL long: result=32'hFFFF_FFFA, hi=32'hFFFF_FFFF, is_long=1, rd_lo=4, rd_hi=5.
  - N+1: write R4=FFFF_FFFA, done=0.
  - N+2: write R5=FFFF_FFFF, done=1.
  - With ALU_WB_PERF_EN: long_wb_count=1.
- Partial flags: flags=4'b1111 preloaded; accept with alu_flags=4'b0100, flag_write=2'b10 → flags=4'b0111.
- Busy ignore: alu_valid during WB_LO with result=32'hDEAD_BEEF → alu_out, flags and writes unaffected; no extra done.
- Reset mid-op: assert reset asynchronously in WB_LO of a long op → wb_en=0 immediately; after release, no WB_HI write; flags=0, alu_ready=1.
- Alias and no-write cases:
  - is_long, rd_lo=rd_hi=7: two writes to R7, last data = hi word.
  - is_long with reg_write=0: wb_en never high, done at N+1.
